// File: rtl/adder_requester.sv
`default_nettype none
// ============================================================================
// Module   : adder_requester
// Purpose  : Initiator-side endpoint for the NoC adder service. It takes an
//            operand pair from a local command port and sends it as a two-beat
//            AXI-Stream packet (A, then B with TLAST). It then waits for a
//            one-beat sum, compares that sum with a locally computed A+B, and
//            reports the result. It also keeps transaction and error counters.
// Ports    : clk_i / rst_ni       clock, asynchronous active-low reset
//            cmd_*                operand command handshake (valid/ready, A, B)
//            axis_m_*             request stream toward the adder node
//            axis_s_*             response stream from the adder node
//            res_*                per-transaction result (pulse + held status)
//            txn_count_o          completed transactions (wrapping)
//            err_count_o          mismatches plus timeouts (wrapping)
// Revision : 1.0  initial release
// ============================================================================
module adder_requester #(
  parameter int                TDATAW         = 32,
  parameter int                TDESTW         = 4,
  parameter int                TIDW           = 2,
  parameter logic [TDESTW-1:0] ADDER_DEST     = 'h1,
  parameter logic [TIDW-1:0]   SRC_ID         = '0,
  parameter int                TIMEOUT_CYCLES = 256,
  parameter int                CNTW           = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [TDATAW-1:0] cmd_a_i,
  input  logic [TDATAW-1:0] cmd_b_i,
  output logic              axis_m_tvalid_o,
  input  logic              axis_m_tready_i,
  output logic [TDATAW-1:0] axis_m_tdata_o,
  output logic              axis_m_tlast_o,
  output logic [TIDW-1:0]   axis_m_tid_o,
  output logic [TDESTW-1:0] axis_m_tdest_o,
  input  logic              axis_s_tvalid_i,
  output logic              axis_s_tready_o,
  input  logic [TDATAW-1:0] axis_s_tdata_i,
  input  logic              axis_s_tlast_i,
  input  logic [TIDW-1:0]   axis_s_tid_i,
  input  logic [TDESTW-1:0] axis_s_tdest_i,
  output logic              res_valid_o,
  output logic [TDATAW-1:0] res_data_o,
  output logic              res_mismatch_o,
  output logic              res_timeout_o,
  output logic [CNTW-1:0]   txn_count_o,
  output logic [CNTW-1:0]   err_count_o
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int            TOW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_A   = 3'd1,
    SEND_B   = 3'd2,
    WAIT_RES = 3'd3,
    REPORT   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q;
  logic [TDATAW-1:0]   a_q, b_q, exp_q;
  logic [TOW-1:0]      to_cnt_q;
  logic [TDATAW-1:0]   res_data_q;
  logic                res_mismatch_q, res_timeout_q;
  logic [CNTW-1:0]     txn_q, err_q;

  logic accept_cmd, got_resp, timed_out, to_clr, to_inc;

  // Response sideband fields carry nothing this endpoint needs.
  logic unused_resp_sideband;
  assign unused_resp_sideband = ^{axis_s_tlast_i, axis_s_tid_i, axis_s_tdest_i};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    accept_cmd = 1'b0;
    got_resp   = 1'b0;
    timed_out  = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        // cmd_ready_q is low on the first cycle out of reset, so gate on it
        // to keep the handshake consistent with what the port shows.
        if (cmd_valid_i && cmd_ready_q) begin
          accept_cmd = 1'b1;
          state_d    = SEND_A;
        end
      end
      SEND_A: begin
        if (axis_m_tready_i) state_d = SEND_B;
      end
      SEND_B: begin
        if (axis_m_tready_i) begin
          to_clr  = 1'b1;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        // A response beat takes priority over a timeout on the same cycle.
        if (axis_s_tvalid_i) begin
          got_resp = 1'b1;
          state_d  = REPORT;
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST)) begin
          timed_out = 1'b1;
          state_d   = REPORT;
        end else begin
          to_inc = 1'b1;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cmd_ready_q    <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      exp_q          <= '0;
      to_cnt_q       <= '0;
      res_data_q     <= '0;
      res_mismatch_q <= 1'b0;
      res_timeout_q  <= 1'b0;
      txn_q          <= '0;
      err_q          <= '0;
    end else begin
      state_q     <= state_d;
      // Registered from the next state so it stays low while in reset.
      cmd_ready_q <= (state_d == IDLE);

      if (accept_cmd) begin
        a_q   <= cmd_a_i;
        b_q   <= cmd_b_i;
        exp_q <= cmd_a_i + cmd_b_i;  // carry out dropped by the width
      end

      if (to_clr) begin
        to_cnt_q <= '0;
      end else if (to_inc) begin
        to_cnt_q <= to_cnt_q + TOW'(1);
      end

      if (got_resp) begin
        res_data_q     <= axis_s_tdata_i;
        res_mismatch_q <= (axis_s_tdata_i != exp_q);
        res_timeout_q  <= 1'b0;
      end else if (timed_out) begin
        res_data_q     <= '0;
        res_mismatch_q <= 1'b0;
        res_timeout_q  <= 1'b1;
      end

      if (state_q == REPORT) begin
        txn_q <= txn_q + CNTW'(1);
        if (res_mismatch_q || res_timeout_q) err_q <= err_q + CNTW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from state and registers only
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready_o     = cmd_ready_q;
    axis_m_tvalid_o = (state_q == SEND_A) || (state_q == SEND_B);
    axis_m_tlast_o  = (state_q == SEND_B);
    axis_m_tdata_o  = '0;
    if (state_q == SEND_A) axis_m_tdata_o = a_q;
    if (state_q == SEND_B) axis_m_tdata_o = b_q;
    axis_m_tid_o    = axis_m_tvalid_o ? SRC_ID : '0;
    axis_m_tdest_o  = axis_m_tvalid_o ? ADDER_DEST : '0;
    axis_s_tready_o = (state_q == WAIT_RES);
    res_valid_o     = (state_q == REPORT);
    res_data_o      = res_data_q;
    res_mismatch_o  = res_mismatch_q;
    res_timeout_o   = res_timeout_q;
    txn_count_o     = txn_q;
    err_count_o     = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_requester
// Purpose  : Self-checking bench for adder_requester (TIMEOUT_CYCLES = 8).
//            A transaction-level reference model tracks the expected sum,
//            mismatch/timeout status and the wrapping counters.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder_requester;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [1:0]  m_tid;
  logic [3:0]  m_tdest;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata;
  logic [1:0]  s_tid;
  logic [3:0]  s_tdest;
  logic        res_valid, res_mm, res_to;
  logic [31:0] res_data;
  logic [15:0] txn_cnt, err_cnt;

  adder_requester #(
    .TDATAW(32), .TDESTW(4), .TIDW(2), .ADDER_DEST(4'h1), .SRC_ID(2'd0),
    .TIMEOUT_CYCLES(TO), .CNTW(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .axis_m_tvalid_o(m_tvalid), .axis_m_tready_i(m_tready),
    .axis_m_tdata_o(m_tdata), .axis_m_tlast_o(m_tlast),
    .axis_m_tid_o(m_tid), .axis_m_tdest_o(m_tdest),
    .axis_s_tvalid_i(s_tvalid), .axis_s_tready_o(s_tready),
    .axis_s_tdata_i(s_tdata), .axis_s_tlast_i(s_tlast),
    .axis_s_tid_i(s_tid), .axis_s_tdest_i(s_tdest),
    .res_valid_o(res_valid), .res_data_o(res_data),
    .res_mismatch_o(res_mm), .res_timeout_o(res_to),
    .txn_count_o(txn_cnt), .err_count_o(err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Free-running cycle counter and handshake monitors.
  int cyc    = 0;
  int n_beat = 0;
  int n_res  = 0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && m_tvalid && m_tready) n_beat = n_beat + 1;
    if (rst_n && res_valid) n_res = n_res + 1;
  end

  // Reference model state.
  int m_txn = 0;
  int m_err = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 50) begin
      tick();
      k++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input int stall);
    for (int s = 0; s <= stall; s++) begin
      check("m_tvalid", m_tvalid, 1);
      check("m_tdata", m_tdata, d);
      check("m_tlast", m_tlast, last);
      check("m_tdest", m_tdest, 4'h1);
      check("m_tid", m_tid, 2'd0);
      check("cmd_ready_busy", cmd_ready, 0);
      m_tready = (s == stall);
      tick();
      m_tready = 1'b0;
    end
  endtask

  // mode 0: respond with resp after delay idle cycles; mode 1: never respond.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input int stall_a,
                        input int stall_b, input int mode, input logic [31:0] resp,
                        input int delay);
    logic [31:0] sum;
    logic [31:0] e_data;
    logic        e_mm, e_to;
    int          n;
    sum = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
    wait_ready();
    acc_cyc   = cyc;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
    cmd_a     = $urandom;
    cmd_b     = $urandom;
    send_beat(a, 1'b0, stall_a);
    send_beat(b, 1'b1, stall_b);
    check("s_tready_wait", s_tready, 1);
    if (mode == 0) begin
      for (int d = 0; d < delay; d++) begin
        check("no_early_res", res_valid, 0);
        tick();
      end
      s_tvalid = 1'b1;
      s_tdata  = resp;
      tick();
      s_tvalid = 1'b0;
      s_tdata  = $urandom;
      e_data = resp;
      e_mm   = (resp != sum);
      e_to   = 1'b0;
    end else begin
      n = 0;
      while (!res_valid && n < 100) begin
        if (s_tready) n++;
        tick();
      end
      check("timeout_len", n, TO);
      e_data = '0;
      e_mm   = 1'b0;
      e_to   = 1'b1;
    end
    m_txn = (m_txn + 1) % 65536;
    if (e_mm || e_to) m_err = (m_err + 1) % 65536;
    check("res_valid", res_valid, 1);
    check("res_data", res_data, e_data);
    check("res_mismatch", res_mm, e_mm);
    check("res_timeout", res_to, e_to);
    check("s_tready_report", s_tready, 0);
    tick();
    check("txn_count", txn_cnt, 16'(m_txn));
    check("err_count", err_cnt, 16'(m_err));
    check("res_valid_pulse", res_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
    check("res_data_held", res_data, e_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int b0, r0;
    logic [31:0] a, b, r;
    rst_n = 1'b0; cmd_valid = 0; cmd_a = 0; cmd_b = 0; m_tready = 0;
    s_tvalid = 0; s_tdata = 0; s_tlast = 0; s_tid = 0; s_tdest = 0;
    repeat (3) tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_txn", txn_cnt, 0);
    check("rst_err", err_cnt, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1);

    // Basic transaction
    do_txn(32'd5, 32'd7, 0, 0, 0, 32'd12, 0);

    // Backpressure on both beats
    do_txn($urandom, $urandom, 3, 3, 0, 32'd0, 1);

    // Overflow: carry discarded, then a wrong sum
    do_txn(32'hFFFF_FFFF, 32'd2, 0, 0, 0, 32'd1, 0);
    do_txn(32'hFFFF_FFFF, 32'd2, 0, 0, 0, 32'd7, 0);

    // Timeout, then a normal transaction
    do_txn(32'd100, 32'd23, 0, 0, 1, 32'd0, 0);
    do_txn(32'd1, 32'd2, 0, 0, 0, 32'd3, 2);

    // Response on the final timeout cycle wins
    do_txn(32'd40, 32'd2, 1, 0, 0, 32'd42, TO - 1);

    // Randomized transactions, some with corrupted sums
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      r = a + b;
      if ($urandom_range(0, 2) == 0) r = r ^ (32'd1 << $urandom_range(0, 31));
      do_txn(a, b, $urandom_range(0, 2), $urandom_range(0, 2), 0, r,
             $urandom_range(0, 5));
    end

    // Reset while stalled in beat B
    wait_ready();
    cmd_valid = 1'b1; cmd_a = 32'd9; cmd_b = 32'd11;
    tick();
    cmd_valid = 1'b0;
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("pre_rst_beat_b", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b1, 32'd11});
    r0 = n_res;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_m_fields", {m_tvalid, m_tlast, m_tid, m_tdest, m_tdata}, 0);
    check("mid_rst_s_tready", s_tready, 0);
    check("mid_rst_res", {res_valid, res_mm, res_to, res_data}, 0);
    check("mid_rst_counts", {txn_cnt, err_cnt}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    m_txn = 0;
    m_err = 0;
    check("after_rst_ready", cmd_ready, 1);
    check("after_rst_txn", txn_cnt, 0);
    check("after_rst_m_tvalid", m_tvalid, 0);
    check("no_res_for_abandoned", n_res, r0);

    // Back-to-back at full rate
    b0 = n_beat;
    r0 = n_res;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      do_txn(a, b, 0, 0, 0, a + b, 0);
      if (i > 0) check("b2b_spacing", acc_cyc - prev, 5);
      prev = acc_cyc;
    end
    check("b2b_beats", n_beat - b0, 8);
    check("b2b_results", n_res - r0, 4);
    check("b2b_txn", txn_cnt, 4);
    check("b2b_err", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
